// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue: register tags, entry bookkeeping, wakeup tag match.
// Latency: none (types and a pure combinational helper).
// Backpressure: not applicable.
package issue_queue_pkg;

  localparam int REG_NUM      = 32;
  localparam int REG_ADDR_W   = $clog2(REG_NUM);
  localparam int IQ_DEPTH_DEF = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Entry bookkeeping. The payload lives in a parallel array so that its
  // width can stay a module parameter.
  typedef struct packed {
    logic      valid;
    reg_addr_t src1;
    reg_addr_t src2;
    logic      src1_rdy;
    logic      src2_rdy;
    logic      rf_we;
    reg_addr_t dest;
  } iq_entry_t;

  // A source is woken by any nonzero broadcast tag equal to it; r0 never wakes.
  function automatic logic tag_hit(input reg_addr_t src, input reg_addr_t t0,
                                   input reg_addr_t t1, input reg_addr_t t2,
                                   input reg_addr_t t3);
    return (src != '0) && ((src == t0) || (src == t1) || (src == t2) || (src == t3));
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Dispatch, wakeup, select and issue signals between decode, the issue queue and execute.
// Latency: not applicable (wires only).
// Backpressure: disp_ready throttles dispatch; issue_stall freezes selection.
interface issue_queue_if
  import issue_queue_pkg::*;
#(
  parameter int PAYLOAD_W = 64
);

  logic                 flush;
  logic                 disp_inst1_valid;
  reg_addr_t            disp_inst1_src1;
  reg_addr_t            disp_inst1_src2;
  logic                 disp_inst1_src1_ready;
  logic                 disp_inst1_src2_ready;
  logic                 disp_inst1_rf_we;
  reg_addr_t            disp_inst1_dest;
  logic [PAYLOAD_W-1:0] disp_inst1_payload;
  logic                 disp_inst2_valid;
  reg_addr_t            disp_inst2_src1;
  reg_addr_t            disp_inst2_src2;
  logic                 disp_inst2_src1_ready;
  logic                 disp_inst2_src2_ready;
  logic                 disp_inst2_rf_we;
  reg_addr_t            disp_inst2_dest;
  logic [PAYLOAD_W-1:0] disp_inst2_payload;
  logic                 disp_ready;
  reg_addr_t            wb_inst1_dest;
  reg_addr_t            wb_inst2_dest;
  logic                 issue_stall;
  logic                 issue_inst1_valid;
  logic [PAYLOAD_W-1:0] issue_inst1_payload;
  logic                 issue_inst2_valid;
  logic [PAYLOAD_W-1:0] issue_inst2_payload;
  reg_addr_t            sel_inst1_dest;
  reg_addr_t            sel_inst2_dest;

  modport master (
    output flush,
    output disp_inst1_valid, disp_inst1_src1, disp_inst1_src2, disp_inst1_src1_ready,
           disp_inst1_src2_ready, disp_inst1_rf_we, disp_inst1_dest, disp_inst1_payload,
    output disp_inst2_valid, disp_inst2_src1, disp_inst2_src2, disp_inst2_src1_ready,
           disp_inst2_src2_ready, disp_inst2_rf_we, disp_inst2_dest, disp_inst2_payload,
    output wb_inst1_dest, wb_inst2_dest, issue_stall,
    input  disp_ready,
    input  issue_inst1_valid, issue_inst1_payload, issue_inst2_valid, issue_inst2_payload,
    input  sel_inst1_dest, sel_inst2_dest
  );

  modport slave (
    input  flush,
    input  disp_inst1_valid, disp_inst1_src1, disp_inst1_src2, disp_inst1_src1_ready,
           disp_inst1_src2_ready, disp_inst1_rf_we, disp_inst1_dest, disp_inst1_payload,
    input  disp_inst2_valid, disp_inst2_src1, disp_inst2_src2, disp_inst2_src1_ready,
           disp_inst2_src2_ready, disp_inst2_rf_we, disp_inst2_dest, disp_inst2_payload,
    input  wb_inst1_dest, wb_inst2_dest, issue_stall,
    output disp_ready,
    output issue_inst1_valid, issue_inst1_payload, issue_inst2_valid, issue_inst2_payload,
    output sel_inst1_dest, sel_inst2_dest
  );

endinterface

// File: rtl/iq_select.sv
// Oldest-first dual picker: one-hot grants for the first and second set request bits.
// Latency: combinational.
// Backpressure: none; caller masks req to suppress selection.
module iq_select #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt1,
  output logic [N-1:0] gnt2
);

  logic got1;
  logic got2;

  // Scan from index 0 (oldest): first request takes slot 1, the next takes slot 2.
  always_comb begin
    gnt1 = '0;
    gnt2 = '0;
    got1 = 1'b0;
    got2 = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (!got1) begin
          gnt1[i] = 1'b1;
          got1    = 1'b1;
        end else if (!got2) begin
          gnt2[i] = 1'b1;
          got2    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing dual-issue queue: holds dispatched uops, wakes sources, issues two oldest ready.
// Latency: dispatch to issue register >= 2 edges; select is combinational, issue is registered.
// Backpressure: disp_ready needs two free slots; issue_stall freezes select and issue regs.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH  = IQ_DEPTH_DEF,
  parameter int PAYLOAD_W = 64
) (
  input logic         clk,
  input logic         reset,
  issue_queue_if.slave io
);

  localparam int             IDX_W   = $clog2(IQ_DEPTH);
  localparam logic [IDX_W:0] DEPTH_C = IQ_DEPTH[IDX_W:0];

  iq_entry_t            ent_q [IQ_DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [IQ_DEPTH];
  iq_entry_t            ent_d [IQ_DEPTH];
  logic [PAYLOAD_W-1:0] pay_d [IQ_DEPTH];

  logic                 iss1_vld_q;
  logic                 iss2_vld_q;
  logic [PAYLOAD_W-1:0] iss1_pay_q;
  logic [PAYLOAD_W-1:0] iss2_pay_q;

  logic [IDX_W:0]       count;
  logic                 disp_ok;
  logic                 acc1;
  logic                 acc2;
  logic                 sel_en;
  logic [IQ_DEPTH-1:0]  req;
  logic [IQ_DEPTH-1:0]  gnt1;
  logic [IQ_DEPTH-1:0]  gnt2;

  logic                 sel1_vld, sel2_vld;
  logic                 sel1_we, sel2_we;
  reg_addr_t            sel1_dst, sel2_dst;
  logic [PAYLOAD_W-1:0] sel1_pay, sel2_pay;
  reg_addr_t            tag_s1, tag_s2;

  iq_entry_t            new1, new2, e;
  logic [IDX_W:0]       n;

  // Occupancy from the current valid bits; same-cycle issue is deliberately ignored.
  always_comb begin
    count = '0;
    for (int i = 0; i < IQ_DEPTH; i++) count = count + (IDX_W+1)'(ent_q[i].valid);
  end

  assign disp_ok = (count <= DEPTH_C - (IDX_W+1)'(2));
  assign acc1    = io.disp_inst1_valid && disp_ok && !io.flush;
  assign acc2    = io.disp_inst2_valid && acc1;
  assign sel_en  = !io.issue_stall && !io.flush;

  // An entry requests issue once both sources are ready (r0 was marked ready at dispatch).
  always_comb begin
    req = '0;
    for (int i = 0; i < IQ_DEPTH; i++)
      req[i] = sel_en && ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
  end

  iq_select #(.N(IQ_DEPTH)) u_select (
    .req  (req),
    .gnt1 (gnt1),
    .gnt2 (gnt2)
  );

  // One-hot mux of the granted entries' dest and payload.
  always_comb begin
    sel1_vld = 1'b0; sel1_we = 1'b0; sel1_dst = '0; sel1_pay = '0;
    sel2_vld = 1'b0; sel2_we = 1'b0; sel2_dst = '0; sel2_pay = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (gnt1[i]) begin
        sel1_vld = 1'b1; sel1_we = ent_q[i].rf_we; sel1_dst = ent_q[i].dest; sel1_pay = pay_q[i];
      end
      if (gnt2[i]) begin
        sel2_vld = 1'b1; sel2_we = ent_q[i].rf_we; sel2_dst = ent_q[i].dest; sel2_pay = pay_q[i];
      end
    end
  end

  assign tag_s1 = (sel1_vld && sel1_we) ? sel1_dst : '0;
  assign tag_s2 = (sel2_vld && sel2_we) ? sel2_dst : '0;

  // New entries: ready if the busy table says so, if r0, or if a tag broadcast this
  // cycle matches (busy table clears one cycle late, so this is the bypass).
  always_comb begin
    new1          = '0;
    new1.valid    = 1'b1;
    new1.src1     = io.disp_inst1_src1;
    new1.src2     = io.disp_inst1_src2;
    new1.src1_rdy = io.disp_inst1_src1_ready || (io.disp_inst1_src1 == '0) ||
                    tag_hit(io.disp_inst1_src1, tag_s1, tag_s2, io.wb_inst1_dest, io.wb_inst2_dest);
    new1.src2_rdy = io.disp_inst1_src2_ready || (io.disp_inst1_src2 == '0) ||
                    tag_hit(io.disp_inst1_src2, tag_s1, tag_s2, io.wb_inst1_dest, io.wb_inst2_dest);
    new1.rf_we    = io.disp_inst1_rf_we;
    new1.dest     = io.disp_inst1_dest;
    new2          = '0;
    new2.valid    = 1'b1;
    new2.src1     = io.disp_inst2_src1;
    new2.src2     = io.disp_inst2_src2;
    new2.src1_rdy = io.disp_inst2_src1_ready || (io.disp_inst2_src1 == '0) ||
                    tag_hit(io.disp_inst2_src1, tag_s1, tag_s2, io.wb_inst1_dest, io.wb_inst2_dest);
    new2.src2_rdy = io.disp_inst2_src2_ready || (io.disp_inst2_src2 == '0) ||
                    tag_hit(io.disp_inst2_src2, tag_s1, tag_s2, io.wb_inst1_dest, io.wb_inst2_dest);
    new2.rf_we    = io.disp_inst2_rf_we;
    new2.dest     = io.disp_inst2_dest;
  end

  // Collapse: survivors pack down in age order with wakeups applied, then dispatch appends.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      ent_d[i] = '0;
      pay_d[i] = '0;
    end
    e = '0;
    n = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (ent_q[i].valid && !gnt1[i] && !gnt2[i]) begin
        e          = ent_q[i];
        e.src1_rdy = e.src1_rdy || tag_hit(e.src1, tag_s1, tag_s2, io.wb_inst1_dest, io.wb_inst2_dest);
        e.src2_rdy = e.src2_rdy || tag_hit(e.src2, tag_s1, tag_s2, io.wb_inst1_dest, io.wb_inst2_dest);
        ent_d[n[IDX_W-1:0]] = e;
        pay_d[n[IDX_W-1:0]] = pay_q[i];
        n = n + 1'b1;
      end
    end
    if (acc1 && (n < DEPTH_C)) begin
      ent_d[n[IDX_W-1:0]] = new1;
      pay_d[n[IDX_W-1:0]] = io.disp_inst1_payload;
      n = n + 1'b1;
    end
    if (acc2 && (n < DEPTH_C)) begin
      ent_d[n[IDX_W-1:0]] = new2;
      pay_d[n[IDX_W-1:0]] = io.disp_inst2_payload;
    end
  end

  // Entry array: flush empties it, otherwise take the collapsed/inserted image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_q[i] <= '0;
        pay_q[i] <= '0;
      end
    end else if (io.flush) begin
      for (int i = 0; i < IQ_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
        pay_q[i] <= pay_d[i];
      end
    end
  end

  // Issue registers: cleared by flush, held while stalled, otherwise load this cycle's picks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss1_vld_q <= 1'b0;
      iss2_vld_q <= 1'b0;
      iss1_pay_q <= '0;
      iss2_pay_q <= '0;
    end else if (io.flush) begin
      iss1_vld_q <= 1'b0;
      iss2_vld_q <= 1'b0;
    end else if (!io.issue_stall) begin
      iss1_vld_q <= sel1_vld;
      iss2_vld_q <= sel2_vld;
      if (sel1_vld) iss1_pay_q <= sel1_pay;
      if (sel2_vld) iss2_pay_q <= sel2_pay;
    end
  end

  assign io.disp_ready          = disp_ok;
  assign io.issue_inst1_valid   = iss1_vld_q;
  assign io.issue_inst2_valid   = iss2_vld_q;
  assign io.issue_inst1_payload = iss1_pay_q;
  assign io.issue_inst2_payload = iss2_pay_q;
  assign io.sel_inst1_dest      = tag_s1;
  assign io.sel_inst2_dest      = tag_s2;

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: queue-based reference model, directed scenarios + random.
// Latency: expectations are queued per cycle and compared on the following falling edge.
// Backpressure: stall, flush and full-queue dispatch are all exercised.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  issue_queue_if #(.PAYLOAD_W(PW)) io ();

  issue_queue #(.IQ_DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  typedef struct {
    reg_addr_t s1, s2;
    logic      r1, r2, we;
    reg_addr_t dest;
    logic [63:0] pay;
  } m_ent_t;

  typedef struct {
    reg_addr_t d1, d2;
    logic      dr;
  } sel_rec_t;

  typedef struct {
    logic        v1, v2;
    logic [63:0] p1, p2;
  } iss_rec_t;

  typedef struct {
    logic      v1, v2;
    reg_addr_t s11, s12, s21, s22;
    logic      r11, r12, r21, r22, we1, we2;
    reg_addr_t d1, d2, wb1, wb2;
    logic      stall, flush;
  } stim_t;

  m_ent_t   mq[$];
  iss_rec_t ereg;
  sel_rec_t sel_q[$];
  iss_rec_t iss_q[$];
  logic     mon_en = 1'b0;
  logic [31:0] pay_cnt = 32'd1;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic hit(input reg_addr_t x, input reg_addr_t a, input reg_addr_t b,
                               input reg_addr_t c, input reg_addr_t d);
    return (x != 0) && (x == a || x == b || x == c || x == d);
  endfunction

  task automatic apply(input stim_t s, input logic [63:0] pa, input logic [63:0] pb);
    io.flush = s.flush;
    io.issue_stall = s.stall;
    io.disp_inst1_valid = s.v1;
    io.disp_inst1_src1 = s.s11;
    io.disp_inst1_src2 = s.s12;
    io.disp_inst1_src1_ready = s.r11;
    io.disp_inst1_src2_ready = s.r12;
    io.disp_inst1_rf_we = s.we1;
    io.disp_inst1_dest = s.d1;
    io.disp_inst1_payload = pa;
    io.disp_inst2_valid = s.v2;
    io.disp_inst2_src1 = s.s21;
    io.disp_inst2_src2 = s.s22;
    io.disp_inst2_src1_ready = s.r21;
    io.disp_inst2_src2_ready = s.r22;
    io.disp_inst2_rf_we = s.we2;
    io.disp_inst2_dest = s.d2;
    io.disp_inst2_payload = pb;
    io.wb_inst1_dest = s.wb1;
    io.wb_inst2_dest = s.wb2;
  endtask

  // Reference model: one cycle of queue behaviour. Pushes this cycle's expected select
  // outputs and the issue register contents expected after the coming edge.
  task automatic step(input stim_t s, input logic [63:0] pa, input logic [63:0] pb);
    sel_rec_t  sr;
    m_ent_t    ne;
    int        ia, ib;
    reg_addr_t t1, t2;
    logic      dr;
    dr = ((DEPTH - mq.size()) >= 2);
    sr.d1 = 0; sr.d2 = 0; sr.dr = dr;
    if (s.flush) begin
      mq.delete();
      ereg.v1 = 1'b0;
      ereg.v2 = 1'b0;
      sel_q.push_back(sr);
      iss_q.push_back(ereg);
      return;
    end
    ia = -1; ib = -1;
    if (!s.stall) begin
      foreach (mq[k]) begin
        if ((mq[k].s1 == 0 || mq[k].r1) && (mq[k].s2 == 0 || mq[k].r2)) begin
          if (ia < 0) ia = k;
          else if (ib < 0) ib = k;
        end
      end
    end
    t1 = 0; t2 = 0;
    if (ia >= 0) begin if (mq[ia].we) t1 = mq[ia].dest; end
    if (ib >= 0) begin if (mq[ib].we) t2 = mq[ib].dest; end
    sr.d1 = t1; sr.d2 = t2;
    if (!s.stall) begin
      ereg.v1 = (ia >= 0);
      ereg.v2 = (ib >= 0);
      if (ia >= 0) ereg.p1 = mq[ia].pay;
      if (ib >= 0) ereg.p2 = mq[ib].pay;
    end
    if (ib >= 0) mq.delete(ib);
    if (ia >= 0) mq.delete(ia);
    foreach (mq[k]) begin
      if (hit(mq[k].s1, t1, t2, s.wb1, s.wb2)) mq[k].r1 = 1'b1;
      if (hit(mq[k].s2, t1, t2, s.wb1, s.wb2)) mq[k].r2 = 1'b1;
    end
    if (s.v1 && dr) begin
      ne.s1 = s.s11; ne.s2 = s.s12; ne.we = s.we1; ne.dest = s.d1; ne.pay = pa;
      ne.r1 = s.r11 || hit(s.s11, t1, t2, s.wb1, s.wb2);
      ne.r2 = s.r12 || hit(s.s12, t1, t2, s.wb1, s.wb2);
      mq.push_back(ne);
      if (s.v2) begin
        ne.s1 = s.s21; ne.s2 = s.s22; ne.we = s.we2; ne.dest = s.d2; ne.pay = pb;
        ne.r1 = s.r21 || hit(s.s21, t1, t2, s.wb1, s.wb2);
        ne.r2 = s.r22 || hit(s.s22, t1, t2, s.wb1, s.wb2);
        mq.push_back(ne);
      end
    end
    sel_q.push_back(sr);
    iss_q.push_back(ereg);
  endtask

  task automatic cyc(input stim_t s);
    logic [63:0] pa, pb;
    @(posedge clk); #1;
    pa = {32'hA5A5_0000, pay_cnt};
    pb = {32'h5A5A_0000, pay_cnt};
    pay_cnt = pay_cnt + 32'd1;
    apply(s, pa, pb);
    step(s, pa, pb);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 1'b0;
    apply(idle(), 64'd0, 64'd0);
    sel_q.delete();
    iss_q.delete();
    #2 reset = 1'b1;
    #1;
    chk("rst_issue1_valid", 64'(io.issue_inst1_valid), 64'd0);
    chk("rst_issue2_valid", 64'(io.issue_inst2_valid), 64'd0);
    chk("rst_issue1_payload", io.issue_inst1_payload, 64'd0);
    chk("rst_issue2_payload", io.issue_inst2_payload, 64'd0);
    chk("rst_disp_ready", 64'(io.disp_ready), 64'd1);
    chk("rst_sel1_dest", 64'(io.sel_inst1_dest), 64'd0);
    chk("rst_sel2_dest", 64'(io.sel_inst2_dest), 64'd0);
    reset = 1'b0;
    mq.delete();
    ereg = '{default: '0};
    iss_q.push_back(ereg);
    step(idle(), 64'd0, 64'd0);
    mon_en = 1'b1;
  endtask

  // Monitor: compare select/disp_ready for this cycle and issue registers after the last edge.
  always @(negedge clk) begin
    sel_rec_t sr;
    iss_rec_t ir;
    if (mon_en) begin
      if (sel_q.size() == 0 || iss_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=empty required=record");
      end else begin
        sr = sel_q.pop_front();
        ir = iss_q.pop_front();
        chk("sel1_dest", 64'(io.sel_inst1_dest), 64'(sr.d1));
        chk("sel2_dest", 64'(io.sel_inst2_dest), 64'(sr.d2));
        chk("disp_ready", 64'(io.disp_ready), 64'(sr.dr));
        chk("issue1_valid", 64'(io.issue_inst1_valid), 64'(ir.v1));
        chk("issue2_valid", 64'(io.issue_inst2_valid), 64'(ir.v2));
        if (ir.v1) chk("issue1_payload", io.issue_inst1_payload, ir.p1);
        if (ir.v2) chk("issue2_payload", io.issue_inst2_payload, ir.p2);
      end
    end
  end

  function automatic stim_t one(input reg_addr_t s1, input logic r1, input reg_addr_t s2,
                                input logic r2, input logic we, input reg_addr_t d);
    stim_t s;
    s = idle();
    s.v1 = 1'b1; s.s11 = s1; s.r11 = r1; s.s12 = s2; s.r12 = r2; s.we1 = we; s.d1 = d;
    return s;
  endfunction

  function automatic stim_t two(input reg_addr_t s1, input logic r1, input reg_addr_t d1,
                                input reg_addr_t s2, input logic r2, input reg_addr_t d2);
    stim_t s;
    s = one(s1, r1, 0, 1'b1, 1'b1, d1);
    s.v2 = 1'b1; s.s21 = s2; s.r21 = r2; s.s22 = 0; s.r22 = 1'b0; s.we2 = 1'b1; s.d2 = d2;
    return s;
  endfunction

  initial begin
    stim_t s;
    apply(idle(), 64'd0, 64'd0);
    do_reset();

    // Producer A (dest r3) and dependent consumer B (src1 r3) in one cycle.
    cyc(two(0, 1'b1, 3, 3, 1'b0, 4));
    repeat (3) cyc(idle());

    // C waits on r5 while r5 is written back in the same cycle.
    s = one(5, 1'b0, 0, 1'b0, 1'b0, 0);
    s.wb2 = 5;
    cyc(s);
    repeat (2) cyc(idle());

    // Fill to 7 entries blocked on r9, hold dispatch while full, then wake them all.
    repeat (3) cyc(two(9, 1'b0, 1, 9, 1'b0, 2));
    cyc(one(9, 1'b0, 0, 1'b1, 1'b1, 6));
    repeat (2) cyc(two(0, 1'b1, 7, 0, 1'b1, 7));
    s = two(0, 1'b1, 7, 0, 1'b1, 7);
    s.wb1 = 9;
    cyc(s);
    repeat (6) cyc(idle());

    // Four ready entries held behind issue_stall, then released in age order.
    s = two(0, 1'b1, 1, 0, 1'b1, 2); s.stall = 1'b1; cyc(s);
    s = two(0, 1'b1, 0, 0, 1'b1, 0); s.stall = 1'b1; cyc(s);
    s = idle(); s.stall = 1'b1;
    repeat (3) cyc(s);
    repeat (3) cyc(idle());

    // Flush with six blocked entries and a ready dispatch pending.
    repeat (3) cyc(two(10, 1'b0, 1, 10, 1'b0, 2));
    s = two(0, 1'b1, 3, 0, 1'b1, 4); s.flush = 1'b1; cyc(s);
    s = idle(); s.wb1 = 10;
    cyc(s);
    repeat (2) cyc(idle());

    // Reset with five entries resident.
    repeat (2) cyc(two(11, 1'b0, 1, 11, 1'b0, 2));
    cyc(one(11, 1'b0, 0, 1'b1, 1'b1, 3));
    do_reset();

    // Randomised traffic over a small register window so dependencies and r0 are common.
    for (int c = 0; c < 600; c++) begin
      s = idle();
      s.v1  = ($urandom_range(0, 99) < 60);
      s.v2  = s.v1 && 1'($urandom_range(0, 1));
      s.s11 = reg_addr_t'($urandom_range(0, 7));
      s.s12 = reg_addr_t'($urandom_range(0, 7));
      s.s21 = reg_addr_t'($urandom_range(0, 7));
      s.s22 = reg_addr_t'($urandom_range(0, 7));
      s.r11 = 1'($urandom_range(0, 1));
      s.r12 = 1'($urandom_range(0, 1));
      s.r21 = 1'($urandom_range(0, 1));
      s.r22 = 1'($urandom_range(0, 1));
      s.we1 = 1'($urandom_range(0, 1));
      s.we2 = 1'($urandom_range(0, 1));
      s.d1  = reg_addr_t'($urandom_range(0, 7));
      s.d2  = reg_addr_t'($urandom_range(0, 7));
      s.wb1 = reg_addr_t'($urandom_range(0, 7));
      s.wb2 = reg_addr_t'($urandom_range(0, 7));
      s.stall = ($urandom_range(0, 99) < 15);
      s.flush = ($urandom_range(0, 99) < 3);
      cyc(s);
    end
    repeat (10) cyc(idle());

    @(negedge clk);
    #1 mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
